ysyx_22040895_mdu: RTL and testbench

YSYX_22040895_MDU -- requirements
Module: ysyx_22040895_mdu

---
 rtl/ysyx_22040895_mdu.sv | 186 ++++++++++++++++++
 tb/tb_ysyx_22040895_mdu.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040895_mdu.sv
// Iterative multiply/divide unit: shift-add mul/mulw, restoring divw/remw.
// One iteration per cycle; divide-by-zero and overflow finish immediately.
module ysyx_22040895_mdu (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i_mdu,
  input  logic [3:0]  mduop_i_mdu,
  input  logic [63:0] src1_i_mdu,
  input  logic [63:0] src2_i_mdu,
  input  logic        flush_i_mdu,
  output logic        ready_o_mdu,
  output logic        busy_o_mdu,
  output logic        valid_o_mdu,
  output logic [63:0] result_o_mdu
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [3:0] OP_MUL  = 4'b0001;
  localparam logic [3:0] OP_MULW = 4'b0101;
  localparam logic [3:0] OP_DIVW = 4'b1001;
  localparam logic [3:0] OP_REMW = 4'b1101;

  state_t      state_q;
  logic [3:0]  op_q;
  logic [6:0]  cnt_q;
  logic [63:0] a_q;
  logic [63:0] b_q;
  logic [63:0] acc_q;
  logic [63:0] res_q;
  logic        neg_q_q;
  logic        neg_r_q;
  logic        spec_q;

  logic        legal;
  logic        accept;
  logic        is_div;
  logic [31:0] s1w;
  logic [31:0] s2w;
  logic [31:0] mag1;
  logic [31:0] mag2;
  logic        div0;
  logic        ovf;
  logic [63:0] spec_res;

  logic [63:0] mul_acc_nx;
  logic [32:0] diff;
  logic        ge;
  logic [31:0] rem_nx;
  logic [31:0] quo_nx;

  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic [63:0] final_res;

  assign legal = (mduop_i_mdu == OP_MUL)  ||
                 (mduop_i_mdu == OP_MULW) ||
                 (mduop_i_mdu == OP_DIVW) ||
                 (mduop_i_mdu == OP_REMW);

  assign accept = valid_i_mdu && (state_q == IDLE)
                  && legal && !flush_i_mdu;

  assign is_div = mduop_i_mdu[3];
  assign s1w    = src1_i_mdu[31:0];
  assign s2w    = src2_i_mdu[31:0];
  assign mag1   = s1w[31] ? -s1w : s1w;
  assign mag2   = s2w[31] ? -s2w : s2w;
  assign div0   = (s2w == 32'd0);
  assign ovf    = (s1w == 32'h8000_0000) && (s2w == 32'hFFFF_FFFF);

  always_comb begin
    spec_res = 64'd0;
    if (div0) begin
      spec_res = mduop_i_mdu[2] ? {{32{s1w[31]}}, s1w}
                                : 64'hFFFF_FFFF_FFFF_FFFF;
    end else if (ovf) begin
      spec_res = mduop_i_mdu[2] ? 64'd0
                                : 64'hFFFF_FFFF_8000_0000;
    end
  end

  // Restoring step: shift the next dividend bit into the partial remainder.
  assign mul_acc_nx = b_q[0] ? acc_q + a_q : acc_q;
  assign diff   = {acc_q[31:0], b_q[31]} - {1'b0, a_q[31:0]};
  assign ge     = ~diff[32];
  assign rem_nx = ge ? diff[31:0] : {acc_q[30:0], b_q[31]};
  assign quo_nx = {b_q[30:0], ge};

  assign quo_s = neg_q_q ? -b_q[31:0] : b_q[31:0];
  assign rem_s = neg_r_q ? -acc_q[31:0] : acc_q[31:0];

  always_comb begin
    final_res = acc_q;
    if (!spec_q) begin
      unique case (1'b1)
        op_q == OP_MULW: final_res = {{32{acc_q[31]}}, acc_q[31:0]};
        op_q == OP_DIVW: final_res = {{32{quo_s[31]}}, quo_s};
        op_q == OP_REMW: final_res = {{32{rem_s[31]}}, rem_s};
        default:         final_res = acc_q;
      endcase
    end
  end

  assign ready_o_mdu  = (state_q == IDLE);
  assign busy_o_mdu   = (state_q != IDLE);
  assign valid_o_mdu  = (state_q == DONE) && !flush_i_mdu;
  assign result_o_mdu = valid_o_mdu ? final_res : res_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= 4'd0;
      cnt_q   <= 7'd0;
      a_q     <= 64'd0;
      b_q     <= 64'd0;
      acc_q   <= 64'd0;
      res_q   <= 64'd0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      spec_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            op_q <= mduop_i_mdu;
            if (is_div && (div0 || ovf)) begin
              spec_q  <= 1'b1;
              acc_q   <= spec_res;
              cnt_q   <= 7'd0;
              state_q <= DONE;
            end else begin
              spec_q  <= 1'b0;
              acc_q   <= 64'd0;
              state_q <= BUSY;
              cnt_q   <= (mduop_i_mdu == OP_MUL) ? 7'd64 : 7'd32;
              neg_q_q <= s1w[31] ^ s2w[31];
              neg_r_q <= s1w[31];
              if (is_div) begin
                a_q <= {32'd0, mag2};
                b_q <= {32'd0, mag1};
              end else if (mduop_i_mdu == OP_MUL) begin
                a_q <= src1_i_mdu;
                b_q <= src2_i_mdu;
              end else begin
                a_q <= {32'd0, s1w};
                b_q <= {32'd0, s2w};
              end
            end
          end
        end
        BUSY: begin
          if (flush_i_mdu) begin
            state_q <= IDLE;
            cnt_q   <= 7'd0;
          end else begin
            cnt_q <= cnt_q - 7'd1;
            if (cnt_q == 7'd1) state_q <= DONE;
            if (op_q[3]) begin
              acc_q <= {32'd0, rem_nx};
              b_q   <= {32'd0, quo_nx};
            end else begin
              acc_q <= mul_acc_nx;
              a_q   <= {a_q[62:0], 1'b0};
              b_q   <= {1'b0, b_q[63:1]};
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          cnt_q   <= 7'd0;
          if (!flush_i_mdu) res_q <= final_res;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 7'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040895_mdu.sv
// Directed bench for ysyx_22040895_mdu: latency, results,
// special cases, flush, reset abort, back-to-back and illegal ops.
module tb_ysyx_22040895_mdu;

  localparam logic [3:0] OP_MUL  = 4'b0001;
  localparam logic [3:0] OP_MULW = 4'b0101;
  localparam logic [3:0] OP_DIVW = 4'b1001;
  localparam logic [3:0] OP_REMW = 4'b1101;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic [3:0]  op;
  logic [63:0] src1;
  logic [63:0] src2;
  logic        flush;
  logic        ready;
  logic        busy;
  logic        valid_o;
  logic [63:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  ysyx_22040895_mdu dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i_mdu  (valid_i),
    .mduop_i_mdu  (op),
    .src1_i_mdu   (src1),
    .src2_i_mdu   (src2),
    .flush_i_mdu  (flush),
    .ready_o_mdu  (ready),
    .busy_o_mdu   (busy),
    .valid_o_mdu  (valid_o),
    .result_o_mdu (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [3:0] o,
                        input logic [63:0] s1, input logic [63:0] s2,
                        input int exp_cyc, input logic [63:0] exp_res);
    int got_cyc;
    int busy_n;
    logic [63:0] got_res;
    got_cyc = 0;
    busy_n  = 0;
    got_res = '0;
    chk({tag, "_ready"}, 64'(ready), 64'd1);
    valid_i = 1'b1;
    op      = o;
    src1    = s1;
    src2    = s2;
    tick();
    valid_i = 1'b0;
    op      = 4'd0;
    src1    = {$urandom, $urandom};
    src2    = {$urandom, $urandom};
    for (int c = 1; c <= 150 && got_cyc == 0; c++) begin
      if (busy) busy_n++;
      if (valid_o) begin
        got_cyc = c;
        got_res = result;
      end else begin
        tick();
      end
    end
    chk({tag, "_cycle"}, 64'(got_cyc), 64'(exp_cyc));
    chk({tag, "_result"}, got_res, exp_res);
    chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_cyc));
    tick();
    chk({tag, "_strobe_off"}, 64'(valid_o), 64'd0);
    chk({tag, "_held"}, result, exp_res);
  endtask

  initial begin
    int vcount;
    int first_c;
    int second_c;
    logic [63:0] r1;
    logic [63:0] r2;

    rst     = 1'b1;
    valid_i = 1'b0;
    op      = 4'd0;
    src1    = '0;
    src2    = '0;
    flush   = 1'b0;
    tick();
    tick();
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_result", result, 64'd0);

    rst = 1'b0;
    run_op("mul", OP_MUL, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB,
           65, 64'hFFFF_FFFF_FFFF_FFF1);

    // flush in cycle 10 of a mul
    valid_i = 1'b1;
    op      = OP_MUL;
    src1    = 64'd9;
    src2    = 64'd9;
    tick();
    valid_i = 1'b0;
    op      = 4'd0;
    for (int c = 1; c < 10; c++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_ready", 64'(ready), 64'd1);
    chk("flush_busy", 64'(busy), 64'd0);
    vcount = 0;
    for (int c = 0; c < 80; c++) begin
      if (valid_o) vcount++;
      tick();
    end
    chk("flush_no_valid", 64'(vcount), 64'd0);
    chk("flush_result_kept", result, 64'hFFFF_FFFF_FFFF_FFF1);

    run_op("mulw", OP_MULW, 64'h7FFF_FFFF, 64'd2,
           33, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("divw", OP_DIVW, 64'hDEAD_BEEF_FFFF_FFF9, 64'd2,
           33, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("remw", OP_REMW, 64'hDEAD_BEEF_FFFF_FFF9, 64'd2,
           33, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("divw_negdiv", OP_DIVW, 64'd7, 64'h1234_5678_FFFF_FFFE,
           33, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("remw_negdiv", OP_REMW, 64'd7, 64'h1234_5678_FFFF_FFFE,
           33, 64'd1);
    run_op("divw_by0", OP_DIVW, 64'd5, 64'hABCD_0000_0000_0000,
           1, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("remw_by0", OP_REMW, 64'd5, 64'd0, 1, 64'd5);
    run_op("divw_ovf", OP_DIVW, 64'h8000_0000, 64'hFFFF_FFFF,
           1, 64'hFFFF_FFFF_8000_0000);
    run_op("remw_ovf", OP_REMW, 64'h8000_0000, 64'hFFFF_FFFF,
           1, 64'd0);

    // illegal op is ignored
    valid_i = 1'b1;
    op      = 4'b0011;
    tick();
    tick();
    chk("illegal_ready", 64'(ready), 64'd1);
    chk("illegal_busy", 64'(busy), 64'd0);

    // flush beats a request in IDLE
    op    = OP_MUL;
    flush = 1'b1;
    tick();
    valid_i = 1'b0;
    flush   = 1'b0;
    chk("flush_idle_busy", 64'(busy), 64'd0);

    // back-to-back: divw then mul held valid
    valid_i = 1'b1;
    op      = OP_DIVW;
    src1    = 64'd100;
    src2    = 64'd7;
    tick();
    op       = OP_MUL;
    src1     = 64'h1234;
    src2     = 64'h10;
    first_c  = 0;
    second_c = 0;
    r1       = '0;
    r2       = '0;
    for (int c = 1; c <= 120; c++) begin
      if (valid_o) begin
        if (first_c == 0) begin
          first_c = c;
          r1 = result;
        end else if (second_c == 0) begin
          second_c = c;
          r2 = result;
        end
      end
      if (c == 34) chk("b2b_ready34", 64'(ready), 64'd1);
      if (c == 35) begin
        chk("b2b_busy35", 64'(busy), 64'd1);
        valid_i = 1'b0;
        op      = 4'd0;
      end
      tick();
    end
    chk("b2b_first_cycle", 64'(first_c), 64'd33);
    chk("b2b_first_result", r1, 64'd14);
    chk("b2b_second_cycle", 64'(second_c), 64'd99);
    chk("b2b_second_result", r2, 64'h12340);

    // reset in cycle 20 of a mul
    valid_i = 1'b1;
    op      = OP_MUL;
    src1    = 64'd11;
    src2    = 64'd13;
    tick();
    valid_i = 1'b0;
    op      = 4'd0;
    for (int c = 1; c < 20; c++) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ready", 64'(ready), 64'd1);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_valid", 64'(valid_o), 64'd0);
    chk("arst_result", result, 64'd0);
    tick();
    tick();
    chk("arst_hold_busy", 64'(busy), 64'd0);
    chk("arst_hold_result", result, 64'd0);
    rst    = 1'b0;
    vcount = 0;
    for (int c = 0; c < 80; c++) begin
      if (valid_o) vcount++;
      tick();
    end
    chk("arst_no_valid", 64'(vcount), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
